// File: rtl/layers_priority_mux_if.sv
// Pixel-side bundle between the object drawers and the layer priority mux.
// The master is the drawer/controller side; the slave is the mux itself.
interface layers_priority_mux_if #(
   parameter int NUM_LAYERS = 4,
   parameter int RGB_W      = 8
);
   localparam int IDX_W = $clog2(NUM_LAYERS);

   logic                        startOfFrame;
   logic [NUM_LAYERS-1:0]       layer_DR;
   logic [NUM_LAYERS*RGB_W-1:0] layer_RGB;
   logic [NUM_LAYERS-1:0]       layer_en;
   logic [NUM_LAYERS-1:0]       blink_mask;
   logic [RGB_W-1:0]            background_RGB;
   logic [RGB_W-1:0]            RGBOut;
   logic [IDX_W-1:0]            winner_idx;
   logic                        any_DR;
   logic                        blink_phase;

   modport master (
      output startOfFrame, layer_DR, layer_RGB, layer_en, blink_mask, background_RGB,
      input  RGBOut, winner_idx, any_DR, blink_phase
   );

   modport slave (
      input  startOfFrame, layer_DR, layer_RGB, layer_en, blink_mask, background_RGB,
      output RGBOut, winner_idx, any_DR, blink_phase
   );
endinterface

// File: rtl/layers_priority_mux.sv
// N-layer priority pixel mux with enable, colour keying and frame-synchronous blinking.
// Two registered stages: qualify draw requests, then priority-select; latency is fixed at 2.
module layers_priority_mux #(
   parameter int               NUM_LAYERS      = 4,
   parameter int               RGB_W           = 8,
   parameter bit               TRANSPARENT_EN  = 1'b1,
   parameter logic [RGB_W-1:0] TRANSPARENT_RGB = 8'hFF,
   parameter int               BLINK_FRAMES    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   layers_priority_mux_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_LAYERS);
   localparam int CNT_W = $clog2(BLINK_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

   logic [CNT_W-1:0]            r_cnt;
   logic                        r_blink_phase;
   logic [NUM_LAYERS-1:0]       w_key_hit;
   logic [NUM_LAYERS-1:0]       w_eff;
   logic [NUM_LAYERS-1:0]       r_eff;
   logic [NUM_LAYERS*RGB_W-1:0] r_rgb;
   logic [RGB_W-1:0]            r_bg;
   logic [RGB_W-1:0]            w_sel_rgb;
   logic [IDX_W-1:0]            w_sel_idx;
   logic                        w_sel_any;
   logic [RGB_W-1:0]            r_rgb_out;
   logic [IDX_W-1:0]            r_idx;
   logic                        r_any;

   // Blink counter: advances on startOfFrame, toggles phase after BLINK_FRAMES pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt         <= '0;
         r_blink_phase <= 1'b1;
      end else if (bus.startOfFrame) begin
         if (r_cnt == CNT_LAST) begin
            r_cnt         <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end else begin
         r_cnt         <= r_cnt;
         r_blink_phase <= r_blink_phase;
      end
   end

   // Stage 1 qualification: a keyed (transparent) pixel never blocks lower layers.
   always_comb begin
      w_key_hit = '0;
      w_eff     = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         w_key_hit[i] = TRANSPARENT_EN &&
                        (bus.layer_RGB[i*RGB_W +: RGB_W] == TRANSPARENT_RGB);
         w_eff[i]     = bus.layer_DR[i] & bus.layer_en[i] &
                        ~(bus.blink_mask[i] & ~r_blink_phase) & ~w_key_hit[i];
      end
   end

   // Stage 1 registers: qualified requests plus the colours they select from.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_eff <= '0;
         r_rgb <= '0;
         r_bg  <= '0;
      end else begin
         r_eff <= w_eff;
         r_rgb <= bus.layer_RGB;
         r_bg  <= bus.background_RGB;
      end
   end

   // Priority encoder: scanning from the top index down lets the lowest index win.
   always_comb begin
      w_sel_rgb = r_bg;
      w_sel_idx = '0;
      w_sel_any = 1'b0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (r_eff[i]) begin
            w_sel_rgb = r_rgb[i*RGB_W +: RGB_W];
            w_sel_idx = IDX_W'(i);
            w_sel_any = 1'b1;
         end else begin
            w_sel_rgb = w_sel_rgb;
            w_sel_idx = w_sel_idx;
            w_sel_any = w_sel_any;
         end
      end
   end

   // Stage 2 output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rgb_out <= '0;
         r_idx     <= '0;
         r_any     <= 1'b0;
      end else begin
         r_rgb_out <= w_sel_rgb;
         r_idx     <= w_sel_idx;
         r_any     <= w_sel_any;
      end
   end

   assign bus.RGBOut      = r_rgb_out;
   assign bus.winner_idx  = r_idx;
   assign bus.any_DR      = r_any;
   assign bus.blink_phase = r_blink_phase;
endmodule

// File: tb/tb_layers_priority_mux.sv
// Scoreboard bench: the driver queues expected pixels, a negedge monitor pops and compares.
// Two DUTs share the stimulus: colour keying on (BLINK_FRAMES=2) and keying off.
module tb_layers_priority_mux;
   logic clk = 1'b0;
   logic rst;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   layers_priority_mux_if #(.NUM_LAYERS(4), .RGB_W(8)) bus1 ();
   layers_priority_mux_if #(.NUM_LAYERS(4), .RGB_W(8)) bus2 ();

   assign bus2.startOfFrame   = bus1.startOfFrame;
   assign bus2.layer_DR       = bus1.layer_DR;
   assign bus2.layer_RGB      = bus1.layer_RGB;
   assign bus2.layer_en       = bus1.layer_en;
   assign bus2.blink_mask     = bus1.blink_mask;
   assign bus2.background_RGB = bus1.background_RGB;

   layers_priority_mux #(.NUM_LAYERS(4), .RGB_W(8), .TRANSPARENT_EN(1'b1),
                         .TRANSPARENT_RGB(8'hFF), .BLINK_FRAMES(2))
      u_dut_key (.clk(clk), .reset(rst), .bus(bus1.slave));

   layers_priority_mux #(.NUM_LAYERS(4), .RGB_W(8), .TRANSPARENT_EN(1'b0),
                         .TRANSPARENT_RGB(8'hFF), .BLINK_FRAMES(2))
      u_dut_nokey (.clk(clk), .reset(rst), .bus(bus2.slave));

   typedef struct {
      int         due;
      logic [7:0] r1;
      logic [1:0] i1;
      logic       a1;
      logic [7:0] r2;
      logic [1:0] i2;
      logic       a2;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   logic m_phase;
   int   m_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: first enabled, visible, non-keyed layer in ascending index order.
   function automatic void model(input logic [3:0] dr, input logic [31:0] rgb,
                                 input logic [3:0] en, input logic [3:0] mask,
                                 input logic ph, input bit tk, input logic [7:0] bg,
                                 output logic [7:0] r, output logic [1:0] idx,
                                 output logic a);
      logic [7:0] c;
      r = bg; idx = 2'd0; a = 1'b0;
      for (int i = 0; i < 4; i++) begin
         c = rgb[i*8 +: 8];
         if (!a && dr[i] && en[i] && !(mask[i] && !ph) && !(tk && c == 8'hFF)) begin
            r = c; idx = 2'(i); a = 1'b1;
         end
      end
   endfunction

   task automatic pix(input logic [3:0] dr, input logic [31:0] rgb, input logic [3:0] en,
                      input logic [3:0] mask, input bit sof, input logic [7:0] bg,
                      input bit hand, input logic [7:0] er, input logic [1:0] ei,
                      input logic ea);
      exp_t e;
      @(negedge clk);
      bus1.layer_DR = dr; bus1.layer_RGB = rgb; bus1.layer_en = en;
      bus1.blink_mask = mask; bus1.startOfFrame = sof; bus1.background_RGB = bg;
      e.due = cyc + 2;
      model(dr, rgb, en, mask, m_phase, 1'b1, bg, e.r1, e.i1, e.a1);
      model(dr, rgb, en, mask, m_phase, 1'b0, bg, e.r2, e.i2, e.a2);
      if (hand) begin
         e.r1 = er; e.i1 = ei; e.a1 = ea;
      end
      q.push_back(e);
      if (sof) begin
         if (m_cnt == 1) begin
            m_cnt = 0; m_phase = ~m_phase;
         end else begin
            m_cnt = m_cnt + 1;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         while (q.size() > 0 && q[0].due <= cyc) begin
            m_e = q.pop_front();
            chk("due_cycle", 32'(m_e.due), 32'(cyc));
            chk("key_rgb", 32'(bus1.RGBOut), 32'(m_e.r1));
            chk("key_idx", 32'(bus1.winner_idx), 32'(m_e.i1));
            chk("key_any", 32'(bus1.any_DR), 32'(m_e.a1));
            chk("nokey_rgb", 32'(bus2.RGBOut), 32'(m_e.r2));
            chk("nokey_idx", 32'(bus2.winner_idx), 32'(m_e.i2));
            chk("nokey_any", 32'(bus2.any_DR), 32'(m_e.a2));
         end
      end
   end

   localparam logic [31:0] RGB4 = {8'h44, 8'h33, 8'h22, 8'h11};

   initial begin
      logic [31:0] rr;
      rst = 1'b1;
      m_phase = 1'b1; m_cnt = 0;
      bus1.layer_DR = 4'd0; bus1.layer_RGB = 32'd0; bus1.layer_en = 4'd0;
      bus1.blink_mask = 4'd0; bus1.startOfFrame = 1'b0; bus1.background_RGB = 8'd0;
      repeat (2) @(negedge clk);
      chk("rst_rgb", 32'(bus1.RGBOut), 32'h0);
      chk("rst_any", 32'(bus1.any_DR), 32'h0);
      chk("rst_idx", 32'(bus1.winner_idx), 32'h0);
      chk("rst_phase", 32'(bus1.blink_phase), 32'h1);
      rst = 1'b0;

      // Priority and latency
      pix(4'b1110, RGB4, 4'hF, 4'h0, 1'b0, 8'h03, 1'b1, 8'h22, 2'd1, 1'b1);
      pix(4'b1111, RGB4, 4'hF, 4'h0, 1'b0, 8'h03, 1'b1, 8'h11, 2'd0, 1'b1);
      // Transparency: keyed layer 0 falls through; all keyed gives background
      pix(4'b0011, {8'h44, 8'h33, 8'h5A, 8'hFF}, 4'hF, 4'h0, 1'b0, 8'h03, 1'b1, 8'h5A, 2'd1, 1'b1);
      pix(4'b1111, 32'hFFFF_FFFF, 4'hF, 4'h0, 1'b0, 8'h03, 1'b1, 8'h03, 2'd0, 1'b0);
      pix(4'b1100, {8'h44, 8'hFF, 8'h22, 8'h11}, 4'hF, 4'h0, 1'b0, 8'h03, 1'b1, 8'h44, 2'd3, 1'b1);
      // Enable mask, including a blink bit on a disabled layer
      pix(4'b1111, RGB4, 4'b1000, 4'h0, 1'b0, 8'h03, 1'b1, 8'h44, 2'd3, 1'b1);
      pix(4'b1111, RGB4, 4'b0000, 4'h0, 1'b0, 8'h07, 1'b1, 8'h07, 2'd0, 1'b0);
      pix(4'b0110, RGB4, 4'b0100, 4'b0010, 1'b0, 8'h07, 1'b1, 8'h33, 2'd2, 1'b1);
      // Blink: two pulses hide layer 0; pixels coincident with a pulse keep the old phase
      pix(4'b0011, RGB4, 4'hF, 4'b0001, 1'b0, 8'h03, 1'b1, 8'h11, 2'd0, 1'b1);
      pix(4'b0011, RGB4, 4'hF, 4'b0001, 1'b1, 8'h03, 1'b1, 8'h11, 2'd0, 1'b1);
      pix(4'b0011, RGB4, 4'hF, 4'b0001, 1'b1, 8'h03, 1'b1, 8'h11, 2'd0, 1'b1);
      pix(4'b0011, RGB4, 4'hF, 4'b0001, 1'b0, 8'h03, 1'b1, 8'h22, 2'd1, 1'b1);
      chk("blink_hidden", 32'(bus1.blink_phase), 32'h0);
      pix(4'b0011, RGB4, 4'hF, 4'b0001, 1'b1, 8'h03, 1'b1, 8'h22, 2'd1, 1'b1);
      pix(4'b0011, RGB4, 4'hF, 4'b0001, 1'b1, 8'h03, 1'b1, 8'h22, 2'd1, 1'b1);
      pix(4'b0011, RGB4, 4'hF, 4'b0001, 1'b0, 8'h03, 1'b1, 8'h11, 2'd0, 1'b1);
      chk("blink_visible", 32'(bus1.blink_phase), 32'h1);

      // Random regression against the reference model
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 4; k++)
            rr[k*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
         pix(4'($urandom_range(0, 15)), rr, 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 255)),
             1'b0, 8'h00, 2'd0, 1'b0);
      end

      // Asynchronous reset mid-stream
      pix(4'b1111, RGB4, 4'hF, 4'h0, 1'b0, 8'h09, 1'b1, 8'h11, 2'd0, 1'b1);
      pix(4'b1111, RGB4, 4'hF, 4'h0, 1'b1, 8'h09, 1'b1, 8'h11, 2'd0, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_rgb", 32'(bus1.RGBOut), 32'h0);
      chk("midrst_any", 32'(bus1.any_DR), 32'h0);
      chk("midrst_phase", 32'(bus1.blink_phase), 32'h1);
      q.delete();
      m_phase = 1'b1; m_cnt = 0;
      @(negedge clk);
      bus1.layer_DR = 4'd0; bus1.startOfFrame = 1'b0; bus1.background_RGB = 8'h03;
      rst = 1'b0;
      @(negedge clk);
      chk("refill_rgb", 32'(bus1.RGBOut), 32'h0);
      pix(4'b0000, RGB4, 4'hF, 4'h0, 1'b0, 8'h03, 1'b1, 8'h03, 2'd0, 1'b0);

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
